mux_nway_stream: RTL and testbench
==================================

// Module: mux_nway_stream
// PURPOSE
//  - Parametrised N-input, WIDTH-bit streaming multiplexer with one registered output stage and valid/ready handshake.
//  - Successor to the 2-to-1 structural mux: generalised in channel count and width.
//  - Two selection modes: explicit select, or round-robin arbitration across valid inputs.
//  - Sits between N producer lanes and a single consumer; sustains one transfer per cycle.
// PARAMETERS
//  N      4   number of input channels (>=2)
//  WIDTH  8   data width per channel
//  SELW   $clog2(N)   select/source index width (derived, not overridden)
//  CNTW   16  width of transfer counter (optional feature only)
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          asynchronous, active-high reset
//  in_data     in   N*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid    in   N          per-channel valid
//  in_ready    out  N          per-channel ready; at most one bit set
//  sel         in   SELW       channel index, used in MODE_SEL
//  mode        in   1          0 = MODE_SEL, 1 = MODE_RR
//  out_data    out  WIDTH      registered output data
//  out_valid   out  1          registered output valid
//  out_ready   in   1          consumer ready
//  out_src     out  SELW       index of the channel that produced out_data
//  xfer_count  out  CNTW       count of completed output handshakes
// BEHAVIOUR
//  - Reset (async, immediate): out_valid=0, out_data=0, out_src=0, xfer_count=0, rr_ptr=N-1 (so ch0 has first priority).
//  - load_en = !out_valid || out_ready. in_ready[g] = load_en && grant_valid (g = granted index), all other bits 0. in_ready is combinational.
//  - MODE_SEL: grant = sel; grant_valid = (sel < N). If sel >= N, no in_ready and no load.
//  - MODE_RR: grant = first i with in_valid[i], searching from rr_ptr+1 mod N upward; grant_valid = |in_valid.
//  - Accept happens when in_valid[g] && in_ready[g]. On the next edge: out_data <= ch g, out_src <= g, out_valid <= 1.
//    rr_ptr <= g only on accept, in either mode.
//  - If load_en and no accept: out_valid <= 0 when out_ready drained the register. Otherwise the register holds.
//  - Latency is 1 cycle input-to-output. Throughput is 1 transfer/cycle with out_ready held high.
//  - Backpressure: while out_valid && !out_ready, out_data and out_src are held stable and all in_ready=0.
//  - Simultaneous drain and accept in one cycle: the register is replaced with new data and out_valid stays 1.
//  - A change to mode or sel affects only the next grant. Data already registered is unaffected.
//  - Reset asserted mid-transfer: pending output is discarded and in_ready drops to 0 while rst=1.
// CONFIGURATION
//  - MUX_NWAY_XFER_CNT_EN defined: xfer_count increments by 1 on every out_valid && out_ready. Wraps from 2^CNTW-1 to 0.
//  - MUX_NWAY_XFER_CNT_EN undefined: xfer_count is tied to 0 and no counter flops are instantiated.
// STRUCTURE
//  - Package mux_nway_pkg holds: MODE_SEL=1'b0, MODE_RR=1'b1, and a clog2 helper function.
//  - Sub-module rr_arbiter_n (params N): inputs req[N], ptr[SELW]; outputs gnt_idx[SELW], gnt_vld.
//    It is purely combinational priority rotation and is used for MODE_RR.
//  - Top level holds the output register, rr_ptr, the mode mux and the optional counter.
// TESTING (N=4, WIDTH=8 unless stated)
//  1. Reset: rst=1 mid-stream with out_valid=1 -> out_valid=0, out_data=8'h00, in_ready=4'b0000 immediately (no clock edge).
//  2. MODE_SEL, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100.
//     Next cycle: out_valid=1, out_data=8'hA5, out_src=2.
//  3. N=3, MODE_SEL, sel=3, in_valid=3'b111 -> in_ready=3'b000 and out_valid stays 0 for 5 cycles.
//  4. Backpressure: out_valid=1 with out_data=8'h3C, out_ready=0 for 3 cycles -> out_data stays 8'h3C, in_ready=0.
//     Raise out_ready -> pending input loads on the same edge the old data drains.
//  5. MODE_RR: in_valid=4'b1111, out_ready=1 after reset -> out_src sequence 0,1,2,3,0, one per cycle.
//     Then in_valid=4'b1010 -> out_src alternates 1,3.
//  6. Counter with CNTW=4 and MUX_NWAY_XFER_CNT_EN defined: 17 handshakes -> xfer_count=1.
//     Same run with the macro undefined -> xfer_count=0 throughout.

Source files
------------

// File: rtl/mux_nway_pkg.sv
// Shared definitions for the N-way streaming multiplexer: selection modes and
// the constant-width helper used for index ports.
package mux_nway_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Returns ceil(log2(v)); at least 1 so a 2-way mux still gets a 1-bit index.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_nway_stream_if.sv
// Stream bundle for mux_nway_stream: N producer lanes, one consumer lane,
// selection controls and the transfer counter.
interface mux_nway_stream_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
);
  import mux_nway_pkg::*;

  localparam int SELW = clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_src;
  logic [CNTW-1:0]    xfer_count;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_src, xfer_count
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_src, xfer_count
  );

endinterface

// File: rtl/mux_nway_stream_arb.sv
// rr_arbiter_n: combinational rotating-priority arbiter. The search starts
// at ptr+1 (mod N), so the last winner has the lowest priority.
module rr_arbiter_n
  import mux_nway_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [clog2(N)-1:0]   gnt_idx,
  output logic                  gnt_vld
);

  localparam int SELW = clog2(N);

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!gnt_vld && req[(int'(ptr) + i) % N]) begin
        gnt_idx = SELW'((int'(ptr) + i) % N);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nway_stream.sv
// N-input streaming mux with a single registered output stage, explicit or
// round-robin selection. Optional handshake counter: MUX_NWAY_XFER_CNT_EN.
module mux_nway_stream
  import mux_nway_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input logic              clk,
  input logic              rst,
  mux_nway_stream_if.slave bus
);

  localparam int SELW = clog2(N);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_idx;
  logic             rr_vld;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic             load_en;
  logic             accept;
  logic [N-1:0]     in_ready_c;
  logic [WIDTH-1:0] grant_data;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_src_q;
  logic             out_valid_q;

  rr_arbiter_n #(.N(N)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (bus.mode == MODE_RR) begin
      grant_idx   = rr_idx;
      grant_valid = rr_vld;
    end else begin
      grant_idx   = bus.sel;
      grant_valid = (int'(bus.sel) < N);
    end
  end

  // Ready is forced low during reset so producers never see a phantom grant.
  always_comb begin
    in_ready_c = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_valid && int'(grant_idx) == i) begin
        in_ready_c[i] = load_en && !rst;
        grant_data    = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept       = |(bus.in_valid & in_ready_c);
  assign bus.in_ready = in_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr      <= SELW'(N - 1);
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_src_q   <= grant_idx;
      rr_ptr      <= grant_idx;
    end else if (load_en) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef MUX_NWAY_XFER_CNT_EN
  logic [CNTW-1:0] xfer_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign bus.xfer_count = xfer_cnt;
`else
  assign bus.xfer_count = '0;
`endif

endmodule

// File: tb/tb_mux_nway_stream.sv
// Directed bench for mux_nway_stream: a 4-way instance (CNTW=4) and a 3-way
// instance for the out-of-range select case.
module tb_mux_nway_stream;
  import mux_nway_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_nway_stream_if #(.N(4), .WIDTH(8), .CNTW(4)) bus4 ();
  mux_nway_stream_if #(.N(3), .WIDTH(8), .CNTW(4)) bus3 ();

  mux_nway_stream #(.N(4), .WIDTH(8), .CNTW(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  mux_nway_stream #(.N(3), .WIDTH(8), .CNTW(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

`ifdef MUX_NWAY_XFER_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus4.in_data   = '0;
    bus4.in_valid  = '0;
    bus4.sel       = '0;
    bus4.mode      = MODE_SEL;
    bus4.out_ready = 1'b0;
    bus3.in_data   = '0;
    bus3.in_valid  = '0;
    bus3.sel       = '0;
    bus3.mode      = MODE_SEL;
    bus3.out_ready = 1'b0;
    tick();
    tick();

    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_out_data", 32'(bus4.out_data), 32'h00);
    check("rst_out_src", 32'(bus4.out_src), 32'd0);
    check("rst_xfer_count", 32'(bus4.xfer_count), 32'd0);
    check("rst_in_ready", 32'(bus4.in_ready), 32'd0);
    rst = 1'b0;

    // explicit select of channel 2
    bus4.mode      = MODE_SEL;
    bus4.sel       = 2'd2;
    bus4.in_valid  = 4'b0100;
    bus4.in_data   = 32'h00A5_0000;
    bus4.out_ready = 1'b1;
    #1;
    check("sel2_in_ready", 32'(bus4.in_ready), 32'b0100);
    tick();
    check("sel2_out_valid", 32'(bus4.out_valid), 32'd1);
    check("sel2_out_data", 32'(bus4.out_data), 32'hA5);
    check("sel2_out_src", 32'(bus4.out_src), 32'd2);
    bus4.in_valid = 4'b0000;
    tick();
    check("sel2_drained", 32'(bus4.out_valid), 32'd0);

    // out-of-range select on the 3-way instance
    bus3.mode      = MODE_SEL;
    bus3.sel       = 2'd3;
    bus3.in_valid  = 3'b111;
    bus3.in_data   = 24'h33_2211;
    bus3.out_ready = 1'b1;
    #1;
    check("n3_sel3_in_ready", 32'(bus3.in_ready), 32'b000);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("n3_sel3_out_valid_c%0d", k), 32'(bus3.out_valid), 32'd0);
    end

    // backpressure: 3C held, 77 waits on channel 1
    bus4.sel       = 2'd1;
    bus4.in_valid  = 4'b0010;
    bus4.in_data   = 32'h0000_3C00;
    bus4.out_ready = 1'b0;
    tick();
    check("bp_load_valid", 32'(bus4.out_valid), 32'd1);
    check("bp_load_data", 32'(bus4.out_data), 32'h3C);
    bus4.in_data = 32'h0000_7700;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_in_ready_c%0d", k), 32'(bus4.in_ready), 32'd0);
      tick();
      check($sformatf("bp_hold_data_c%0d", k), 32'(bus4.out_data), 32'h3C);
      check($sformatf("bp_hold_valid_c%0d", k), 32'(bus4.out_valid), 32'd1);
    end
    bus4.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus4.in_ready), 32'b0010);
    tick();
    check("bp_swap_valid", 32'(bus4.out_valid), 32'd1);
    check("bp_swap_data", 32'(bus4.out_data), 32'h77);
    check("bp_swap_src", 32'(bus4.out_src), 32'd1);
    bus4.in_valid = 4'b0000;
    tick();
    check("bp_drained", 32'(bus4.out_valid), 32'd0);

    // round robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    bus4.mode      = MODE_RR;
    bus4.in_valid  = 4'b1111;
    bus4.in_data   = 32'h4433_2211;
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_all_src_%0d", k), 32'(bus4.out_src), 32'(k % 4));
      check($sformatf("rr_all_data_%0d", k), 32'(bus4.out_data), 32'h11 * 32'((k % 4) + 1));
      check($sformatf("rr_all_valid_%0d", k), 32'(bus4.out_valid), 32'd1);
    end
    bus4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_alt_src_%0d", k), 32'(bus4.out_src), (k % 2 == 0) ? 32'd1 : 32'd3);
      check($sformatf("rr_alt_data_%0d", k), 32'(bus4.out_data), (k % 2 == 0) ? 32'h22 : 32'h44);
    end

    // reset asserted while the output register is full
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus4.out_data), 32'h00);
    check("midrst_out_src", 32'(bus4.out_src), 32'd0);
    check("midrst_in_ready", 32'(bus4.in_ready), 32'd0);
    tick();

    // 17 handshakes on a 4-bit counter; first edge only loads
    rst           = 1'b0;
    bus4.in_valid = 4'b0001;
    bus4.in_data  = 32'h0000_005A;
    tick();
    check("cnt_first_load", 32'(bus4.xfer_count), 32'd0);
    for (int k = 2; k <= 17; k++) tick();
    check("cnt_wrap_16", 32'(bus4.xfer_count), 32'd0);
    tick();
    check("cnt_17", 32'(bus4.xfer_count), CNT_ON ? 32'd1 : 32'd0);
    check("cnt_data", 32'(bus4.out_data), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
